// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared types and opcode fields for the memory-wait stage controller
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    MWC_IDLE = 2'd0,
    MWC_BUSY = 2'd1,
    MWC_DONE = 2'd2,
    MWC_ERR  = 2'd3
  } mwc_state_t;

  localparam int         OPC_MEM_MSB  = 6;
  localparam int         OPC_MEM_LSB  = 5;
  localparam logic [1:0] OPC_MEM_VAL  = 2'b10;
  localparam int         OPC_LOAD_BIT = 4;

  localparam int MWC_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - 8-bit BUSY-cycle counter; expires on the LIMIT-th enabled cycle
module mem_wait_timer #(
  parameter logic [7:0] LIMIT = 8'd255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  logic [7:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 8'd0;
    end else if (i_clear) begin
      r_count <= 8'd0;
    end else if (i_enable) begin
      r_count <= r_count + 8'd1;
    end
  end

  // Count starts at 0 in the first enabled cycle, so LIMIT-1 marks the LIMIT-th one.
  assign o_expire = i_enable && (r_count == (LIMIT - 8'd1));

endmodule

// File: rtl/memory_wait_controller.sv
// rtl/memory_wait_controller.sv - memory-wait stage FSM; optional timeout via MEM_WAIT_TIMEOUT_EN
module memory_wait_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = MWC_TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_in,
  input  logic [6:0] opcode,
  input  logic [3:0] rt,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       stall,
  output logic       wb_en,
  output logic [3:0] wb_rd,
  output logic       status_rdy,
  output logic       timeout_err
);

  mwc_state_t r_state;
  mwc_state_t w_next;
  logic       r_is_load;
  logic [3:0] r_rt;
  logic [3:0] r_wb_rd;
  logic       w_is_mem;
  logic       w_accept;
  logic       w_expire;
  logic       w_unused_opc;

  assign w_is_mem     = (opcode[OPC_MEM_MSB:OPC_MEM_LSB] == OPC_MEM_VAL);
  assign w_accept     = (r_state == MWC_IDLE) && valid_in && w_is_mem;
  assign w_unused_opc = ^opcode[3:0];

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_timeout_out_of_range
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      MWC_IDLE: if (w_accept) w_next = MWC_BUSY;
      MWC_BUSY: begin
        if (mem_ack) begin
          w_next = MWC_DONE;
        end else if (w_expire) begin
          w_next = MWC_ERR;
        end
      end
      default:  w_next = MWC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= MWC_IDLE;
      r_is_load <= 1'b0;
      r_rt      <= 4'd0;
      r_wb_rd   <= 4'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_rt      <= rt;
        r_is_load <= opcode[OPC_LOAD_BIT];
      end
      // Writeback index only moves when a load completes, so it holds otherwise.
      if ((r_state == MWC_BUSY) && mem_ack && r_is_load) begin
        r_wb_rd <= r_rt;
      end
    end
  end

  // Outputs are forced to their reset values while rst_n is low, independent of valid_in.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    stall      = 1'b0;
    wb_en      = 1'b0;
    status_rdy = 1'b1;
    if (rst_n) begin
      unique case (r_state)
        MWC_IDLE: begin
          stall      = w_accept;
          status_rdy = !w_accept;
        end
        MWC_BUSY: begin
          mem_req    = 1'b1;
          mem_we     = !r_is_load;
          stall      = 1'b1;
          status_rdy = 1'b0;
        end
        MWC_DONE: wb_en = r_is_load;
        default:  ;
      endcase
    end
  end

  assign wb_rd = r_wb_rd;

`ifdef MEM_WAIT_TIMEOUT_EN
  localparam logic [7:0] LP_LIMIT = 8'(TIMEOUT_CYCLES);

  logic r_timeout_err;

  mem_wait_timer #(
    .LIMIT (LP_LIMIT)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (r_state != MWC_BUSY),
    .i_enable (r_state == MWC_BUSY),
    .o_expire (w_expire)
  );

  // An ack in the expiring cycle takes priority, so the error only sets without one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timeout_err <= 1'b0;
    end else if ((r_state == MWC_BUSY) && !mem_ack && w_expire) begin
      r_timeout_err <= 1'b1;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_expire    = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_memory_wait_controller.sv
// tb/tb_memory_wait_controller.sv - directed bench for memory_wait_controller (MEM_WAIT_TIMEOUT_EN optional)
module tb_memory_wait_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid_in = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic [3:0] rt = 4'd0;
  logic       mem_ack = 1'b0;
  logic       mem_req;
  logic       mem_we;
  logic       stall;
  logic       wb_en;
  logic [3:0] wb_rd;
  logic       status_rdy;
  logic       timeout_err;
  logic [4:0] obs;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [6:0] OP_LOAD  = 7'b1010000;
  localparam logic [6:0] OP_STORE = 7'b1000000;
  localparam logic [6:0] OP_ALU   = 7'b0010000;

  always #5 clk = ~clk;

  // {mem_req, mem_we, stall, wb_en, status_rdy}
  assign obs = {mem_req, mem_we, stall, wb_en, status_rdy};

  memory_wait_controller #(
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_in    (valid_in),
    .opcode      (opcode),
    .rt          (rt),
    .mem_ack     (mem_ack),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .stall       (stall),
    .wb_en       (wb_en),
    .wb_rd       (wb_rd),
    .status_rdy  (status_rdy),
    .timeout_err (timeout_err)
  );

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    n_cmp++;
    if (obs !== 5'b00001) begin
      n_bad++;
      $display("FAIL reset_outputs got=%b exp=%b", obs, 5'b00001);
    end
    n_cmp++;
    if ({wb_rd, timeout_err} !== 5'b00000) begin
      n_bad++;
      $display("FAIL reset_wb_rd_terr got=%b exp=%b", {wb_rd, timeout_err}, 5'b00000);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== 5'b00001) begin
      n_bad++;
      $display("FAIL reset_release_idle got=%b exp=%b", obs, 5'b00001);
    end
  endtask

  task automatic test_load;
    logic [4:0] exp_v [0:4];
    int stall_cnt;
    int wb_cnt;
    exp_v = '{5'b00100, 5'b10100, 5'b10100, 5'b00011, 5'b00001};
    stall_cnt = 0;
    wb_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      valid_in = (c == 0);
      opcode   = (c == 0) ? OP_LOAD : 7'd0;
      rt       = (c == 0) ? 4'h5 : 4'h0;
      mem_ack  = (c == 2);
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_v[c]) begin
        n_bad++;
        $display("FAIL load_c%0d outputs got=%b exp=%b", c, obs, exp_v[c]);
      end
      if (stall) stall_cnt++;
      if (wb_en) wb_cnt++;
      if (c == 3) begin
        n_cmp++;
        if (wb_rd !== 4'h5) begin
          n_bad++;
          $display("FAIL load_wb_rd got=%h exp=%h", wb_rd, 4'h5);
        end
      end
    end
    n_cmp++;
    if (stall_cnt != 3) begin
      n_bad++;
      $display("FAIL load_stall_cycles got=%0d exp=%0d", stall_cnt, 3);
    end
    n_cmp++;
    if (wb_cnt != 1) begin
      n_bad++;
      $display("FAIL load_wb_en_cycles got=%0d exp=%0d", wb_cnt, 1);
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_store;
    logic [4:0] exp_v [0:3];
    int req_cnt;
    int wb_cnt;
    exp_v = '{5'b00100, 5'b11100, 5'b00001, 5'b00001};
    req_cnt = 0;
    wb_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      valid_in = (c == 0);
      opcode   = (c == 0) ? OP_STORE : 7'd0;
      rt       = (c == 0) ? 4'h3 : 4'h0;
      mem_ack  = (c == 1);
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_v[c]) begin
        n_bad++;
        $display("FAIL store_c%0d outputs got=%b exp=%b", c, obs, exp_v[c]);
      end
      if (mem_req) req_cnt++;
      if (wb_en) wb_cnt++;
    end
    n_cmp++;
    if (wb_rd !== 4'h5) begin
      n_bad++;
      $display("FAIL store_wb_rd_hold got=%h exp=%h", wb_rd, 4'h5);
    end
    n_cmp++;
    if ({req_cnt[3:0], wb_cnt[3:0]} !== 8'h10) begin
      n_bad++;
      $display("FAIL store_req_wb_counts got=%0d/%0d exp=1/0", req_cnt, wb_cnt);
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [4:0] exp_v [0:6];
    exp_v = '{5'b00100, 5'b10100, 5'b00011, 5'b00100, 5'b11100, 5'b00001, 5'b00001};
    for (int c = 0; c < 7; c++) begin
      next_cycle();
      valid_in = (c == 0) || (c == 3);
      opcode   = (c == 0) ? OP_LOAD : ((c == 3) ? OP_STORE : 7'd0);
      rt       = (c == 0) ? 4'h9 : ((c == 3) ? 4'h2 : 4'h0);
      mem_ack  = (c == 1) || (c == 4);
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_v[c]) begin
        n_bad++;
        $display("FAIL b2b_c%0d outputs got=%b exp=%b", c, obs, exp_v[c]);
      end
      if ((c == 2) || (c == 5)) begin
        n_cmp++;
        if (wb_rd !== 4'h9) begin
          n_bad++;
          $display("FAIL b2b_c%0d wb_rd got=%h exp=%h", c, wb_rd, 4'h9);
        end
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_non_mem;
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      valid_in = (c < 6);
      opcode   = (c < 6) ? OP_ALU : OP_LOAD;
      rt       = 4'hC;
      mem_ack  = c[0];
      @(negedge clk);
      n_cmp++;
      if (obs !== 5'b00001) begin
        n_bad++;
        $display("FAIL nonmem_c%0d outputs got=%b exp=%b", c, obs, 5'b00001);
      end
    end
    valid_in = 1'b0;
    opcode   = 7'd0;
    mem_ack  = 1'b0;
  endtask

  task automatic test_reset_mid_busy;
    next_cycle();
    valid_in = 1'b1;
    opcode   = OP_LOAD;
    rt       = 4'h7;
    @(negedge clk);
    n_cmp++;
    if (obs !== 5'b00100) begin
      n_bad++;
      $display("FAIL rstbusy_accept got=%b exp=%b", obs, 5'b00100);
    end
    next_cycle();
    valid_in = 1'b0;
    opcode   = 7'd0;
    @(negedge clk);
    n_cmp++;
    if (obs !== 5'b10100) begin
      n_bad++;
      $display("FAIL rstbusy_busy got=%b exp=%b", obs, 5'b10100);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 5'b00001) begin
      n_bad++;
      $display("FAIL rstbusy_async_drop got=%b exp=%b", obs, 5'b00001);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      mem_ack = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({obs, wb_rd} !== {5'b00001, 4'h0}) begin
        n_bad++;
        $display("FAIL rstbusy_after_c%0d got=%b/%h exp=%b/%h", c, obs, wb_rd, 5'b00001, 4'h0);
      end
    end
    mem_ack = 1'b0;
  endtask

`ifdef MEM_WAIT_TIMEOUT_EN
  task automatic test_timeout_ack_wins;
    logic [4:0] exp_v [0:6];
    exp_v = '{5'b00100, 5'b10100, 5'b10100, 5'b10100, 5'b10100, 5'b00011, 5'b00001};
    for (int c = 0; c < 7; c++) begin
      next_cycle();
      valid_in = (c == 0);
      opcode   = (c == 0) ? OP_LOAD : 7'd0;
      rt       = (c == 0) ? 4'h2 : 4'h0;
      mem_ack  = (c == 4);
      @(negedge clk);
      n_cmp++;
      if ({obs, timeout_err} !== {exp_v[c], 1'b0}) begin
        n_bad++;
        $display("FAIL ackwins_c%0d got=%b/%b exp=%b/0", c, obs, timeout_err, exp_v[c]);
      end
      if (c == 5) begin
        n_cmp++;
        if (wb_rd !== 4'h2) begin
          n_bad++;
          $display("FAIL ackwins_wb_rd got=%h exp=%h", wb_rd, 4'h2);
        end
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_timeout;
    logic [4:0] exp_v [0:7];
    logic       exp_te [0:7];
    exp_v  = '{5'b00100, 5'b11100, 5'b11100, 5'b11100, 5'b11100, 5'b00001, 5'b00001, 5'b00001};
    exp_te = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      valid_in = (c == 0);
      opcode   = (c == 0) ? OP_STORE : 7'd0;
      rt       = 4'h0;
      mem_ack  = (c >= 6);
      @(negedge clk);
      n_cmp++;
      if ({obs, timeout_err} !== {exp_v[c], exp_te[c]}) begin
        n_bad++;
        $display("FAIL timeout_c%0d got=%b/%b exp=%b/%b", c, obs, timeout_err, exp_v[c], exp_te[c]);
      end
    end
    mem_ack = 1'b0;
  endtask
`else
  task automatic test_no_timeout;
    for (int c = 0; c < 12; c++) begin
      logic [4:0] exp_o;
      exp_o = (c == 0) ? 5'b00100 : (c <= 9) ? 5'b10100 : (c == 10) ? 5'b00011 : 5'b00001;
      next_cycle();
      valid_in = (c == 0);
      opcode   = (c == 0) ? OP_LOAD : 7'd0;
      rt       = (c == 0) ? 4'h4 : 4'h0;
      mem_ack  = (c == 9);
      @(negedge clk);
      n_cmp++;
      if ({obs, timeout_err} !== {exp_o, 1'b0}) begin
        n_bad++;
        $display("FAIL notimeout_c%0d got=%b/%b exp=%b/0", c, obs, timeout_err, exp_o);
      end
      if (c == 10) begin
        n_cmp++;
        if (wb_rd !== 4'h4) begin
          n_bad++;
          $display("FAIL notimeout_wb_rd got=%h exp=%h", wb_rd, 4'h4);
        end
      end
    end
    mem_ack = 1'b0;
  endtask
`endif

  initial begin
    #50000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load();
    test_store();
    test_back_to_back();
    test_non_mem();
    test_reset_mid_busy();
`ifdef MEM_WAIT_TIMEOUT_EN
    test_timeout_ack_wins();
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/memory_wait_controller.md
MEMORY_WAIT_CONTROLLER -- requirements
Module: memory_wait_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max cycles to wait for mem_ack (range 1..255).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- valid_in  in  1  memory-wait stage holds a valid instruction
- opcode  in  7  decoded opcode from the memory-wait pipeline stage
- rt  in  4  load/store target register from the stage
- mem_ack  in  1  data memory completion strobe
- mem_req  out  1  data memory request, held until acknowledged
- mem_we  out  1  1 = store, 0 = load; valid while mem_req = 1
- stall  out  1  freeze upstream stages and hold the stage contents
- wb_en  out  1  one-cycle register writeback strobe for a completed load
- wb_rd  out  4  writeback register index; valid while wb_en = 1
- status_rdy  out  1  stage idle or completing; no memory op outstanding
- timeout_err  out  1  sticky: memory failed to respond

Function
REQ-003 SHALL classify opcode as a memory op when opcode[6:5] = 2'b10; opcode[4] = 1 is a load, 0 is a store.
REQ-004 SHALL implement the FSM states IDLE, BUSY, DONE and ERR.
REQ-005 In IDLE with valid_in = 1 and a memory op, SHALL latch rt and the load/store bit, assert stall combinationally in that same cycle, and enter BUSY on the next edge.
REQ-006 In IDLE with a non-memory op or valid_in = 0, SHALL keep stall = 0 and status_rdy = 1, and remain in IDLE.
REQ-007 In BUSY, SHALL drive mem_req = 1, drive mem_we from the latched bit, and keep stall = 1; the first mem_req rises 1 cycle after acceptance.
REQ-008 In BUSY with mem_ack = 1, SHALL enter DONE on the next edge, with mem_req dropping at that edge.
REQ-009 In DONE (one cycle), SHALL drive stall = 0 and status_rdy = 1; for a load SHALL also drive wb_en = 1 and wb_rd = latched rt. DONE SHALL then return to IDLE.
REQ-010 A new memory op presented in the cycle after DONE SHALL be accepted per REQ-005, giving a minimum of 3 cycles per memory op when mem_ack arrives in the first BUSY cycle.
REQ-011 mem_ack outside BUSY SHALL be ignored.
REQ-012 status_rdy SHALL be 0 in BUSY and in the IDLE acceptance cycle.
REQ-013 wb_en SHALL be 0 in every state other than DONE-for-load; wb_rd SHALL hold its last value otherwise.

Reset
REQ-014 When rst_n = 0, SHALL asynchronously force state = IDLE, mem_req = 0, mem_we = 0, stall = 0, wb_en = 0, wb_rd = 0, status_rdy = 1 and timeout_err = 0, and clear the timer and latches.
REQ-015 Reset asserted in BUSY SHALL drop mem_req immediately without waiting for a clock edge; the aborted op SHALL produce no wb_en.

Configuration
REQ-016 With MEM_WAIT_TIMEOUT_EN defined, SHALL count BUSY cycles. After TIMEOUT_CYCLES cycles with no mem_ack, SHALL enter ERR, drop mem_req, and set timeout_err = 1, which stays set until reset.
REQ-017 ERR SHALL last one cycle with stall = 0 and wb_en = 0, then return to IDLE.
REQ-018 If mem_ack arrives in the same cycle the count expires, mem_ack SHALL win: the FSM goes to DONE and timeout_err does not set.
REQ-019 Without MEM_WAIT_TIMEOUT_EN, SHALL omit the counter and the ERR state, tie timeout_err to 0, and wait in BUSY indefinitely.

Structure
REQ-020 Package cpu_ctrl_pkg SHALL hold the FSM state enum (mwc_state_t), the memory/load opcode field positions and values, and the default TIMEOUT_CYCLES.
REQ-021 The timeout counter SHALL be a sub-module mem_wait_timer (8-bit, with clear/enable/expire ports), instantiated only under MEM_WAIT_TIMEOUT_EN.

Verification
REQ-022 Load (opcode 7'b1010000, rt 4'h5), mem_ack 2 cycles after mem_req -> stall high 3 cycles, then wb_en = 1 with wb_rd = 5 for exactly 1 cycle.
REQ-023 Store (opcode 7'b1000000) with mem_ack in the first BUSY cycle -> mem_we = 1, mem_req high 1 cycle, wb_en never asserts, 3-cycle op.
REQ-024 Non-memory opcode 7'b0010000 with stray mem_ack pulses -> stall = 0, mem_req = 0, status_rdy = 1 throughout.
REQ-025 rst_n pulled low mid-BUSY (between edges) -> mem_req and stall fall immediately; no wb_en after reset release.
REQ-026 MEM_WAIT_TIMEOUT_EN with TIMEOUT_CYCLES = 4 and no mem_ack -> timeout_err rises after 4 BUSY cycles, stays set, FSM returns to IDLE.
REQ-027 MEM_WAIT_TIMEOUT_EN with TIMEOUT_CYCLES = 4 and mem_ack on the 4th BUSY cycle -> DONE entered, timeout_err stays 0.
